commit_wb_sink: RTL
===================

Name: commit_wb_sink

Overview:
- Consumer end of the commit interface: takes the slave modport of VX_commit_if and terminates the commit stream.
- Buffers incoming commits in a 2-entry elastic queue.
- Issues register-file writebacks for commits with wb=1.
- Emits a per-warp retire pulse on end-of-packet (eop) and keeps retired-instruction and committed-thread counters.
- Sits between the per-core commit arbiter and the GPR writeback port.

Parameters:
- NUM_THREADS, `NUM_THREADS: lanes per warp; tmask/data width.
- XLEN, `XLEN: data and PC width.
- NW_BITS, `UP(`NW_BITS): warp-id width.
- NR_BITS, `NR_BITS: register-index width.
- UUID_BITS, `UP(`UUID_BITS): uuid width.
- PERF_W, 44: width of both performance counters.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- commit_valid  in  1  commit_if.slave valid.
- commit_uuid  in  UUID_BITS  commit_if.slave uuid.
- commit_wid  in  NW_BITS  commit_if.slave wid.
- commit_tmask  in  NUM_THREADS  commit_if.slave tmask.
- commit_PC  in  XLEN  commit_if.slave PC.
- commit_data  in  NUM_THREADS*XLEN  commit_if.slave data.
- commit_rd  in  NR_BITS  commit_if.slave rd.
- commit_wb  in  1  commit_if.slave wb.
- commit_eop  in  1  commit_if.slave eop.
- commit_ready  out  1  commit_if.slave ready.
- wb_valid  out  1  writeback request.
- wb_wid  out  NW_BITS  writeback warp.
- wb_tmask  out  NUM_THREADS  lanes to write.
- wb_rd  out  NR_BITS  destination register.
- wb_data  out  NUM_THREADS*XLEN  write data.
- wb_ready  in  1  register file accepts writeback.
- retire_valid  out  1  one-cycle pulse per retired instruction.
- retire_wid  out  NW_BITS  warp of the retired instruction.
- instr_retired  out  PERF_W  count of eop commits dequeued.
- thread_commits  out  PERF_W  sum of popcount(tmask) over dequeued commits.

Behaviour:
- Reset (async assert, sync deassert via reset_n low→high):
  - Queue empty, count=0.
  - Outputs: commit_ready=1, wb_valid=0, retire_valid=0, retire_wid=0, counters=0.
  - Reset mid-operation discards all queued entries; no writeback or retire is emitted for them.
- Queue:
  - 2 entries, registered storage. Entry = {uuid, wid, tmask, PC, data, rd, wb, eop}.
  - Entry count 0..2.
- Enqueue:
  - enq = commit_valid && commit_ready.
  - commit_ready = (count != 2). It is registered and has no combinational path from wb_ready.
- Head:
  - head_valid = (count != 0). No bypass: a commit accepted in cycle N is visible at the head no earlier than cycle N+1.
- Writeback:
  - wb_valid = head_valid && head.wb.
  - wb_wid/tmask/rd/data are driven from the head entry.
  - Outputs hold stable while wb_valid && !wb_ready.
- Dequeue:
  - deq = head_valid && (!head.wb || wb_ready).
  - Commits with wb=0 drain in one cycle without asserting wb_valid.
- Count update:
  - enq && !deq: +1.
  - deq && !enq: −1.
  - Both: unchanged.
  - Enqueue while count==2 cannot occur (ready=0).
  - Dequeue while count==0 cannot occur.
- Throughput: 1 commit/cycle sustained while wb_ready=1.
- Retire:
  - On a cycle-N dequeue with head.eop=1: retire_valid=1 and retire_wid=head.wid in cycle N+1 (registered).
  - Otherwise retire_valid=0, and retire_wid holds its last value.
- Counters (registered, updated the cycle after deq):
  - instr_retired += head.eop.
  - thread_commits += popcount(head.tmask), zero-extended to PERF_W.
  - Both wrap modulo 2^PERF_W.
- Assertions (simulation only):
  - commit_valid implies tmask != 0.
  - Commit fields stable while commit_valid && !commit_ready.
  - count <= 2.

Decomposition:
- Shared package: commit_entry_t struct (fields above) and its width constant, plus PERF_W default.
- One sub-module is natural: elastic_buf2, a generic 2-entry valid/ready queue parameterised by DATAW.
- commit_wb_sink holds the wb/retire logic and the counters.

Test Plan:
- Reset: hold reset_n=0, drive commit_valid=1 → commit_ready=1, wb_valid=0, retire_valid=0, counters=0; no enqueue observed while reset_n=0.
- Single commit, wb=1 eop=1 tmask=4'b1011 rd=5 wid=2, wb_ready=1, accepted cycle 0:
  - cycle 1: wb_valid=1, wb_rd=5, wb_wid=2.
  - cycle 2: retire_valid=1, retire_wid=2, instr_retired=1, thread_commits=3.
- Backpressure: wb_ready=0, 3 back-to-back wb=1 commits → two accepted, commit_ready=0 from cycle 2. Raise wb_ready → entries drained in order by uuid, then third accepted; ready never combinationally follows wb_ready.
- wb=0 commits: 4 back-to-back, eop=1 each, tmask=all-ones, wb_ready=0 → wb_valid never 1; 4 retire pulses on consecutive cycles; instr_retired=4, thread_commits=4*NUM_THREADS.
- Multi-packet instruction: 3 commits with eop=0,0,1 on wid=1 → exactly one retire pulse, after the third dequeue; instr_retired=1.
- Wrap and mid-run reset:
  - Preload counters near 2^PERF_W−1 via force, then commit tmask popcount=2 → thread_commits wraps to 1.
  - Assert reset_n=0 with 2 queued entries → queue empty and no wb/retire after reset release.

Source files
------------

// File: rtl/commit_wb_sink_pkg.sv
// Shared types and sizing for the commit writeback sink: the queued commit
// entry, its packed width, and a lane-count helper.
package commit_wb_sink_pkg;

  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NW_BITS     = 2;
  localparam int NR_BITS     = 5;
  localparam int UUID_BITS   = 8;
  localparam int PERF_W      = 44;
  localparam int POP_W       = $clog2(NUM_THREADS + 1);

  typedef struct packed {
    logic [UUID_BITS-1:0]        uuid;
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [XLEN-1:0]             pc;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic [NR_BITS-1:0]          rd;
    logic                        wb;
    logic                        eop;
  } commit_entry_t;

  localparam int COMMIT_ENTRY_W = $bits(commit_entry_t);

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt += {{(POP_W-1){1'b0}}, mask[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/commit_wb_sink_elastic_buf2.sv
// Generic 2-entry valid/ready queue. The head is visible only from registered
// storage and in_ready is registered, so neither side sees the other combinationally.
module elastic_buf2 #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);

  logic [DATAW-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             enq;
  logic             deq;

  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (enq && !deq)      count_next = count + 2'd1;
    else if (deq && !enq) count_next = count - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: payload storage is deliberately not reset; count gates every read,
  // so stale contents are never observed and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

  a_count_max: assert property (@(posedge clk) disable iff (!reset_n) count <= 2'd2);

endmodule

// File: rtl/commit_wb_sink.sv
// Terminates the commit stream: buffers commits, issues GPR writebacks for
// wb=1 entries, pulses retire on end-of-packet and keeps perf counters.
module commit_wb_sink
  import commit_wb_sink_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        commit_valid,
  input  logic [UUID_BITS-1:0]        commit_uuid,
  input  logic [NW_BITS-1:0]          commit_wid,
  input  logic [NUM_THREADS-1:0]      commit_tmask,
  input  logic [XLEN-1:0]             commit_PC,
  input  logic [NUM_THREADS*XLEN-1:0] commit_data,
  input  logic [NR_BITS-1:0]          commit_rd,
  input  logic                        commit_wb,
  input  logic                        commit_eop,
  output logic                        commit_ready,
  output logic                        wb_valid,
  output logic [NW_BITS-1:0]          wb_wid,
  output logic [NUM_THREADS-1:0]      wb_tmask,
  output logic [NR_BITS-1:0]          wb_rd,
  output logic [NUM_THREADS*XLEN-1:0] wb_data,
  input  logic                        wb_ready,
  output logic                        retire_valid,
  output logic [NW_BITS-1:0]          retire_wid,
  output logic [PERF_W-1:0]           instr_retired,
  output logic [PERF_W-1:0]           thread_commits
);

  commit_entry_t             in_entry;
  commit_entry_t             head;
  logic [COMMIT_ENTRY_W-1:0] head_flat;
  logic                      head_valid;
  logic                      head_ready;
  logic                      deq;
  logic                      unused_fields;

  assign in_entry = '{uuid: commit_uuid, wid: commit_wid, tmask: commit_tmask,
                      pc: commit_PC, data: commit_data, rd: commit_rd,
                      wb: commit_wb, eop: commit_eop};

  elastic_buf2 #(.DATAW(COMMIT_ENTRY_W)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (commit_valid),
    .in_data   (in_entry),
    .in_ready  (commit_ready),
    .out_valid (head_valid),
    .out_data  (head_flat),
    .out_ready (head_ready)
  );

  assign head = commit_entry_t'(head_flat);

  // Entries without a writeback drain immediately; wb_ready only matters for wb=1.
  assign head_ready = !head.wb || wb_ready;
  assign deq        = head_valid && head_ready;

  assign wb_valid = head_valid && head.wb;
  assign wb_wid   = head.wid;
  assign wb_tmask = head.tmask;
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;

  // uuid and PC travel with the entry for debug but have no consumer here.
  assign unused_fields = ^{head.uuid, head.pc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_valid   <= 1'b0;
      retire_wid     <= '0;
      instr_retired  <= '0;
      thread_commits <= '0;
    end else begin
      retire_valid <= deq && head.eop;
      if (deq && head.eop) retire_wid <= head.wid;
      if (deq) begin
        instr_retired  <= instr_retired + {{(PERF_W-1){1'b0}}, head.eop};
        thread_commits <= thread_commits + {{(PERF_W-POP_W){1'b0}}, popcount(head.tmask)};
      end
    end
  end

  a_tmask_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
    commit_valid |-> (commit_tmask != '0));

  a_commit_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (commit_valid && !commit_ready) |=> (commit_valid && $stable(in_entry)));

endmodule
